// File: rtl/stage_skid_buffer_pkg.sv
// -----------------------------------------------------------------------------
// stage_skid_buffer_pkg
//
// Purpose : Shared constants and helpers for the two-entry pipeline skid
//           buffer and its optional performance counters.
//
// Contents:
//   DATA_BUS_WIDTH  - default payload width, mirrors the shared bus width
//   PERF_CNT_WIDTH  - width of each performance counter
//   sat_inc()       - saturating increment used by sat_counter
//
// Optional feature macro: STAGE_SKID_PERF_EN (see stage_skid_buffer.sv).
// -----------------------------------------------------------------------------
package stage_skid_buffer_pkg;

    localparam int DATA_BUS_WIDTH = 32;
    localparam int PERF_CNT_WIDTH = 32;

    // Increment a 32-bit counter, sticking at all-ones instead of wrapping.
    function automatic logic [PERF_CNT_WIDTH-1:0] sat_inc(
        input logic [PERF_CNT_WIDTH-1:0] value
    );
        if (&value) begin
            return value;
        end
        return value + PERF_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/stage_skid_buffer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//
// Purpose : 32-bit event counter with enable that saturates at all-ones.
//           Used for the stall and bubble statistics of stage_skid_buffer.
//
// Ports:
//   clk    in   clock, counts on rising edge
//   rst    in   asynchronous active-low reset, loads RESET_VALUE
//   en     in   count this cycle
//   count  out  current counter value
//
// RESET_VALUE exists so a counter can start close to the top of its range
// when the saturation behaviour itself needs exercising.
// -----------------------------------------------------------------------------
module sat_counter
    import stage_skid_buffer_pkg::*;
#(
    parameter logic [PERF_CNT_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    output logic [PERF_CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= RESET_VALUE;
        end else if (en) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/stage_skid_buffer.sv
// -----------------------------------------------------------------------------
// stage_skid_buffer
//
// Purpose : Two-entry pipeline stage (main + skid register) that fully
//           decouples the upstream ready from the downstream ready while
//           still sustaining one transfer per cycle. A whole pipeline stage
//           bundle (e.g. MEM-to-WB fields concatenated) can go through one
//           instance instead of per-field stall/flush flops.
//
// Parameters:
//   WIDTH       payload width in bits (1..256), defaults to the data bus width
//   RESET_DATA  value loaded into both data registers on reset
//
// Ports:
//   clk            in   single clock, rising edge
//   rst            in   asynchronous active-low reset
//   flush          in   synchronous flush, drops every held entry
//   in_valid       in   upstream presents in_data
//   in_ready       out  stage accepts a payload this cycle (registered)
//   in_data        in   upstream payload
//   out_valid      out  out_data is valid
//   out_ready      in   downstream consumes out_data this cycle
//   out_data       out  payload to downstream
//   stall_cycles   out  (STAGE_SKID_PERF_EN only) cycles with out_valid & !out_ready
//   bubble_cycles  out  (STAGE_SKID_PERF_EN only) cycles with !out_valid
//
// Handshake: a transfer happens on a side exactly when valid and ready are
// both 1 at a rising edge. Once out_valid is raised, out_valid and out_data
// stay unchanged until out_ready is seen (or flush/reset). in_ready is a flop
// equal to "skid register empty", so nothing combinational runs from
// out_ready to in_ready.
//
// Optional feature macro: STAGE_SKID_PERF_EN adds the two counter outputs.
// -----------------------------------------------------------------------------
module stage_skid_buffer
    import stage_skid_buffer_pkg::*;
#(
    parameter int               WIDTH      = DATA_BUS_WIDTH,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data
`ifdef STAGE_SKID_PERF_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] stall_cycles,
    output logic [PERF_CNT_WIDTH-1:0] bubble_cycles
`endif
);

    // Stage state
    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             in_ready_q;

    // Next-state values
    logic             main_valid_nxt;
    logic [WIDTH-1:0] main_data_nxt;
    logic             skid_valid_nxt;
    logic [WIDTH-1:0] skid_data_nxt;

    logic accept;
    logic release_main;
    logic main_free;

    assign accept       = in_valid & in_ready_q;
    assign release_main = main_valid & out_ready;
    // Main can take a new payload at this edge if it is empty or being drained.
    assign main_free    = ~main_valid | release_main;

    always_comb begin
        main_valid_nxt = main_valid;
        main_data_nxt  = main_data;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;

        if (main_free) begin
            if (skid_valid) begin
                // Older payload waiting in skid has priority; in_ready is
                // already 0 here so no input can be accepted this cycle.
                main_valid_nxt = 1'b1;
                main_data_nxt  = skid_data;
                skid_valid_nxt = 1'b0;
            end else if (accept) begin
                main_valid_nxt = 1'b1;
                main_data_nxt  = in_data;
            end else begin
                main_valid_nxt = 1'b0;
            end
        end else if (accept) begin
            // Main is stalled: park the payload in skid; in_ready falls next cycle.
            skid_valid_nxt = 1'b1;
            skid_data_nxt  = in_data;
        end
    end

    // Control state. Flush wins over any accept/release in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
            in_ready_q <= ~skid_valid_nxt;
        end
    end

    // Data registers keep their contents across a flush; only the valid bits
    // are cleared, so stale data is harmless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_data <= RESET_DATA;
            skid_data <= RESET_DATA;
        end else if (!flush) begin
            main_data <= main_data_nxt;
            skid_data <= skid_data_nxt;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data;

`ifdef STAGE_SKID_PERF_EN
    // Statistics look only at the output side and ignore flush.
    sat_counter u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (main_valid & ~out_ready),
        .count (stall_cycles)
    );

    sat_counter u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (~main_valid),
        .count (bubble_cycles)
    );
`endif

endmodule

// File: tb/tb_stage_skid_buffer.sv
module tb_stage_skid_buffer;

  localparam int W = 16;
  localparam logic [W-1:0] RST_VAL = 16'h5A5A;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
`ifdef STAGE_SKID_PERF_EN
  logic [31:0]  stall_cycles;
  logic [31:0]  bubble_cycles;
`endif

  logic         sat_en = 1'b0;
  logic [31:0]  sat_count;

  stage_skid_buffer #(.WIDTH(W), .RESET_DATA(RST_VAL)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data)
`ifdef STAGE_SKID_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .bubble_cycles (bubble_cycles)
`endif
  );

  // Counter preloaded near the top of its range to exercise saturation.
  sat_counter #(.RESET_VALUE(32'hFFFF_FFFD)) u_sat (
    .clk   (clk),
    .rst   (rst),
    .en    (sat_en),
    .count (sat_count)
  );

  // ---------------- scoreboard / model ----------------
  // The stage behaves as a 2-deep FIFO whose head is the output and whose
  // ready is "fewer than two entries held" as of the last edge.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  longint unsigned exp_stall = 0;
  longint unsigned exp_bubble = 0;
  int n_vec = 0;
  int n_fail = 0;

  function automatic logic [31:0] sat32(input longint unsigned v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("out_valid", out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
    check("in_ready", in_ready, exp_q.size() < 2);
`ifdef STAGE_SKID_PERF_EN
    check("stall_cycles", stall_cycles, sat32(exp_stall));
    check("bubble_cycles", bubble_cycles, sat32(exp_bubble));
`endif
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge: drive, compare, advance one edge, update model.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    bit acc;
    bit rel;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    compare_all();
    acc = v && (exp_q.size() < 2);
    rel = r && (exp_q.size() > 0);
    if (out_valid === 1'b1 && r) got_q.push_back(out_data);
    if (exp_q.size() > 0 && !r) exp_stall++;
    if (exp_q.size() == 0) exp_bubble++;
    @(posedge clk);
    #1;
    if (f) begin
      exp_q.delete();
    end else begin
      if (rel) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(d);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    longint unsigned s0;
    longint unsigned b0;

    // Power-on reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_data", out_data, RST_VAL);
    check("sat_reset", sat_count, 32'hFFFF_FFFD);
    #3 rst = 1'b1;

    // Saturating counter near the top of its range
    sat_en = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    check("sat_inc", sat_count, 32'hFFFF_FFFE);
    step(1'b0, '0, 1'b1, 1'b0);
    check("sat_max", sat_count, 32'hFFFF_FFFF);
    step(1'b0, '0, 1'b1, 1'b0);
    check("sat_hold", sat_count, 32'hFFFF_FFFF);
    sat_en = 1'b0;

    // Streaming 1..8 at full rate
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, W'(k), 1'b1, 1'b0);
      check("stream_valid", out_valid, 1'b1);
      check("stream_data", out_data, W'(k));
      check("stream_ready", in_ready, 1'b1);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: A, B fill both entries, C held off until space returns
    got_q.delete();
    step(1'b1, 16'h000A, 1'b0, 1'b0);
    step(1'b1, 16'h000B, 1'b0, 1'b0);
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_head", out_data, 16'h000A);
    step(1'b1, 16'h000C, 1'b0, 1'b0);
    step(1'b1, 16'h000C, 1'b0, 1'b0);
    check("bp_stable", out_data, 16'h000A);
    step(1'b1, 16'h000C, 1'b1, 1'b0);
    step(1'b1, 16'h000C, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("bp_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("bp_first", got_q[0], 16'h000A);
      check("bp_second", got_q[1], 16'h000B);
      check("bp_third", got_q[2], 16'h000C);
    end

    // Flush colliding with release and a new input
    step(1'b1, 16'h0011, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 1'b0, 1'b0);
    step(1'b1, 16'h000D, 1'b1, 1'b1);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    got_q.delete();
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("flush_no_d", got_q.size(), 0);

`ifdef STAGE_SKID_PERF_EN
    // 5 stalled cycles then 3 empty cycles (plus the empty cycle before the push)
    s0 = stall_cycles;
    b0 = bubble_cycles;
    step(1'b1, 16'h0033, 1'b0, 1'b0);
    repeat (5) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    check("perf_stall_delta", stall_cycles - s0, 5);
    check("perf_bubble_delta", bubble_cycles - b0, 4);
`else
    s0 = 0;
    b0 = 0;
`endif

    // Reset mid-stream with two entries held
    step(1'b1, 16'h0044, 1'b0, 1'b0);
    step(1'b1, 16'h0055, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_data", out_data, RST_VAL);
`ifdef STAGE_SKID_PERF_EN
    check("mid_rst_stall", stall_cycles, 0);
    check("mid_rst_bubble", bubble_cycles, 0);
`endif
    exp_q.delete();
    exp_stall = 0;
    exp_bubble = 0;
    #2 rst = 1'b1;
    step(1'b1, 16'h0077, 1'b1, 1'b0);
    check("post_rst_accept", out_data, 16'h0077);
    check("post_rst_valid", out_valid, 1'b1);

    // Randomized traffic, mixed backpressure and occasional flush
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 3) != 0),
           W'($urandom),
           (i < 400) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 39) == 0));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_skid_buffer.md
STAGE_SKID_BUFFER -- requirements
Module: stage_skid_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 SHALL have parameter RESET_DATA, default 0, WIDTH-bit value loaded into data registers on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush; discards all held entries.
REQ-006 SHALL have port in_valid  input  1  upstream presents a payload.
REQ-007 SHALL have port in_ready  output  1  stage accepts a payload this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port out_valid  output  1  out_data is valid.
REQ-010 SHALL have port out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  payload to downstream.

Function
REQ-012 SHALL hold up to two entries: main register (drives out_data/out_valid) and skid register.
REQ-013 SHALL drive in_ready from a flop as NOT skid_valid; no combinational path from out_ready to in_ready.
REQ-014 SHALL accept on in_valid AND in_ready; release on out_valid AND out_ready.
REQ-015 SHALL present an accepted payload on out_data one cycle after acceptance when main is empty or released that cycle (latency 1).
REQ-016 SHALL, when main is valid, not released, and a payload is accepted, write it into skid; in_ready drops the next cycle.
REQ-017 SHALL, when main is released and skid is valid, move skid to main and clear skid; a new input is not accepted that cycle (in_ready already 0).
REQ-018 SHALL preserve strict FIFO order; no payload duplicated or dropped except by flush.
REQ-019 SHALL sustain one transfer per cycle with out_ready held 1 and in_valid held 1.
REQ-020 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, on flush=1 at an edge, clear main and skid valid bits and set in_ready=1; flush overrides any simultaneous accept or release; data registers hold their values.
REQ-022 SHALL ignore in_data when the payload is not accepted.

Reset
REQ-023 SHALL, while rst=0, force out_valid=0, skid valid=0, in_ready=1, main and skid data=RESET_DATA, independent of clk.
REQ-024 SHALL discard any in-flight entries on reset mid-operation; first acceptance possible at the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL implement macro STAGE_SKID_PERF_EN; when defined, add outputs stall_cycles (32) and bubble_cycles (32).
REQ-026 SHALL with STAGE_SKID_PERF_EN increment stall_cycles on each cycle with out_valid=1 AND out_ready=0, and bubble_cycles on each cycle with out_valid=0, both saturating at 0xFFFFFFFF, reset to 0 by rst, unaffected by flush.
REQ-027 SHALL without STAGE_SKID_PERF_EN omit both ports and counters; handshake behaviour identical.

Structure
REQ-028 SHALL take WIDTH defaults from shared header bus.v widths (DATA_BUS_WIDTH, ADDR_BUS_WIDTH) at instantiation; STAGE_SKID_PERF_EN defined in the shared global define header.
REQ-029 SHALL implement each perf counter as instances of one sub-module sat_counter (32-bit, enable, saturating, async active-low reset).
REQ-030 SHALL allow stage registers (e.g. MEM-to-WB) to be built from one instance per concatenated bundle, replacing per-field stall/flush flops.

Verification
REQ-031 Reset: rst=0 mid-stream with two entries held -> out_valid=0, in_ready=1, out_data=RESET_DATA immediately; counters 0.
REQ-032 Streaming: in_valid=1 with data 1..8, out_ready=1 -> out_data 1..8 on consecutive cycles, first one cycle after accept, in_ready never 0.
REQ-033 Backpressure: push 0xA, 0xB with out_ready=0 -> in_ready=0 after second accept, 0xC held off; out_ready=1 -> outputs 0xA, 0xB, 0xC in order, none lost.
REQ-034 Flush collision: both entries full, flush=1 with out_ready=1 and in_valid=1 (0xD) -> next cycle out_valid=0, in_ready=1, 0xD never appears.
REQ-035 Perf (STAGE_SKID_PERF_EN): 5 stalled cycles then 3 empty cycles -> stall_cycles=5, bubble_cycles=3 (plus reset-idle cycles counted); preloaded near-max counter saturates at 0xFFFFFFFF.
